// File: rtl/fizzbuzz_multi_if.sv
// Stream and control bundle for fizzbuzz_multi: start/enable, divisors,
// downstream ready and the number/hit/last beat with status flags.
interface fizzbuzz_multi_if #(
  parameter int g_length    = 20,
  parameter int g_channels  = 2,
  parameter int g_div_width = 4
);
  localparam int c_num_w = $clog2(g_length + 1);

  logic                              i_en;
  logic [g_channels*g_div_width-1:0] i_div;
  logic                              i_ready;
  logic                              o_valid;
  logic [c_num_w-1:0]                o_number;
  logic [g_channels-1:0]             o_hit;
  logic                              o_last;
  logic                              o_busy;
  logic                              o_done;

  // Controller / downstream side
  modport master (
    output i_en, i_div, i_ready,
    input  o_valid, o_number, o_hit, o_last, o_busy, o_done
  );

  // Counter side
  modport slave (
    input  i_en, i_div, i_ready,
    output o_valid, o_number, o_hit, o_last, o_busy, o_done
  );
endinterface

// File: rtl/fizzbuzz_multi.sv
// Streams 1..g_length over valid/ready and flags, per channel, divisibility
// by a divisor latched at start. Divisibility is tracked with per-channel
// residue counters instead of divider hardware.
module fizzbuzz_multi #(
  parameter int g_length    = 20,
  parameter int g_channels  = 2,
  parameter int g_div_width = 4,
  parameter int g_wrap      = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fizzbuzz_multi_if.slave bus
);
  localparam int                 c_num_w = $clog2(g_length + 1);
  localparam logic [c_num_w-1:0] c_last  = c_num_w'(g_length);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                                 state_r, state_next;
  logic [c_num_w-1:0]                     number_r, number_next;
  logic [g_channels-1:0][g_div_width-1:0] div_r, div_next;
  logic [g_channels-1:0][g_div_width-1:0] res_r, res_next;
  logic [g_channels-1:0]                  hit_r, hit_next;
  logic                                   last_r, last_next;
  logic                                   xfer;

  // Residue after loading number 1: divisor 1 divides everything.
  function automatic logic [g_div_width-1:0] res_init(input logic [g_div_width-1:0] d);
    return (d == g_div_width'(1)) ? '0 : g_div_width'(1);
  endfunction

  // Residue after incrementing the number by one (modular wrap at d-1).
  function automatic logic [g_div_width-1:0] res_adv(input logic [g_div_width-1:0] r,
                                                      input logic [g_div_width-1:0] d);
    return (r == d - g_div_width'(1)) ? '0 : r + g_div_width'(1);
  endfunction

  // A zero divisor disables its channel.
  function automatic logic hit_of(input logic [g_div_width-1:0] r,
                                  input logic [g_div_width-1:0] d);
    return (d != '0) && (r == '0);
  endfunction

  // Next-state, next-number and next-residue logic; hit/last derived from next values
  always_comb begin
    state_next  = state_r;
    number_next = number_r;
    div_next    = div_r;
    res_next    = res_r;
    hit_next    = '0;
    last_next   = 1'b0;
    xfer        = (state_r == S_RUN) && bus.i_en && bus.i_ready;

    case (state_r)
      S_IDLE: begin
        if (bus.i_en) begin
          state_next  = S_RUN;
          div_next    = bus.i_div;
          number_next = c_num_w'(1);
          for (int k = 0; k < g_channels; k++) begin
            res_next[k] = res_init(bus.i_div[k*g_div_width +: g_div_width]);
          end
        end else begin
          number_next = '0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (number_r == c_last) begin
            if (g_wrap != 0) begin
              number_next = c_num_w'(1);
              for (int k = 0; k < g_channels; k++) begin
                res_next[k] = res_init(div_r[k]);
              end
            end else begin
              state_next = S_DONE;
            end
          end else begin
            number_next = number_r + c_num_w'(1);
            for (int k = 0; k < g_channels; k++) begin
              res_next[k] = res_adv(res_r[k], div_r[k]);
            end
          end
        end else begin
          state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (!bus.i_en) begin
          state_next  = S_IDLE;
          number_next = '0;
        end else begin
          state_next = S_DONE;
        end
      end
      default: begin
        state_next  = S_IDLE;
        number_next = '0;
      end
    endcase

    if (state_next != S_IDLE) begin
      for (int k = 0; k < g_channels; k++) begin
        hit_next[k] = hit_of(res_next[k], div_next[k]);
      end
    end else begin
      hit_next = '0;
    end
    last_next = (number_next == c_last);
  end

  // State, number, divisor, residue and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= S_IDLE;
      number_r <= '0;
      div_r    <= '0;
      res_r    <= '0;
      hit_r    <= '0;
      last_r   <= 1'b0;
    end else begin
      state_r  <= state_next;
      number_r <= number_next;
      div_r    <= div_next;
      res_r    <= res_next;
      hit_r    <= hit_next;
      last_r   <= last_next;
    end
  end

  // Valid follows i_en in RUN so a pause withdraws it in the same cycle.
  assign bus.o_valid  = (state_r == S_RUN) && bus.i_en;
  assign bus.o_number = number_r;
  assign bus.o_hit    = hit_r;
  assign bus.o_last   = last_r;
  assign bus.o_busy   = (state_r == S_RUN);
  assign bus.o_done   = (state_r == S_DONE);
endmodule

// File: tb/tb_fizzbuzz_multi.sv
// Directed bench for fizzbuzz_multi: a one-shot and a wrap-mode instance,
// expected beats queued at start and compared as each beat transfers.
module tb_fizzbuzz_multi;
  localparam int c_len = 20;

  typedef struct packed {
    logic [4:0] number;
    logic [1:0] hit;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       ready = 1'b0;
  logic [9:0] div = 10'd0;
  logic       sel = 1'b0;

  int    n_assert = 0;
  int    n_fail = 0;
  beat_t sb[$];

  bit         prev_stall = 1'b0;
  logic [4:0] held_num;
  logic [1:0] held_hit;
  logic       held_last;

  fizzbuzz_multi_if #(.g_length(c_len), .g_channels(2), .g_div_width(5)) ai ();
  fizzbuzz_multi_if #(.g_length(c_len), .g_channels(2), .g_div_width(5)) wi ();

  fizzbuzz_multi #(.g_length(c_len), .g_channels(2), .g_div_width(5), .g_wrap(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(ai)
  );
  fizzbuzz_multi #(.g_length(c_len), .g_channels(2), .g_div_width(5), .g_wrap(1)) dut_w (
    .i_clk(clk), .i_rst(rst), .bus(wi)
  );

  assign ai.i_en    = en && !sel;
  assign ai.i_div   = div;
  assign ai.i_ready = ready;
  assign wi.i_en    = en && sel;
  assign wi.i_div   = div;
  assign wi.i_ready = ready;

  logic       o_valid, o_last, o_busy, o_done;
  logic [4:0] o_number;
  logic [1:0] o_hit;
  assign o_valid  = sel ? wi.o_valid  : ai.o_valid;
  assign o_number = sel ? wi.o_number : ai.o_number;
  assign o_hit    = sel ? wi.o_hit    : ai.o_hit;
  assign o_last   = sel ? wi.o_last   : ai.o_last;
  assign o_busy   = sel ? wi.o_busy   : ai.o_busy;
  assign o_done   = sel ? wi.o_done   : ai.o_done;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] exp_hit(input int n, input logic [9:0] d);
    logic [1:0] h;
    int dk;
    h = 2'b00;
    for (int k = 0; k < 2; k++) begin
      dk = int'(d[k*5 +: 5]);
      h[k] = (dk != 0) && ((n % dk) == 0);
    end
    return h;
  endfunction

  task automatic push(input int n, input logic [9:0] d);
    beat_t b;
    b.number = 5'(n);
    b.hit    = exp_hit(n, d);
    b.last   = (n == c_len);
    sb.push_back(b);
  endtask

  // One clock: compare at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (prev_stall && o_valid) begin
      check("stall_number", 32'(o_number), 32'(held_num));
      check("stall_hit", 32'(o_hit), 32'(held_hit));
      check("stall_last", 32'(o_last), 32'(held_last));
    end
    if (o_valid && ready) begin
      if (sb.size() == 0) begin
        check("sb_entries_on_beat", 32'(sb.size()), 32'd1);
      end else begin
        b = sb.pop_front();
        check("beat_number", 32'(o_number), 32'(b.number));
        check("beat_hit", 32'(o_hit), 32'(b.hit));
        check("beat_last", 32'(o_last), 32'(b.last));
      end
    end
    prev_stall = o_valid && !ready;
    held_num   = o_number;
    held_hit   = o_hit;
    held_last  = o_last;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_number"}, 32'(o_number), 32'd0);
    check({tag, "_hit"}, 32'(o_hit), 32'd0);
    check({tag, "_last"}, 32'(o_last), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  // Full one-shot run from IDLE back to IDLE.
  task automatic run(input logic [9:0] d, input bit rnd, input int pause_at, input logic [9:0] d_mid);
    bit paused = 1'b0;
    bit changed = 1'b0;
    div = d;
    for (int n = 1; n <= c_len; n++) push(n, d);
    en = 1'b1;
    ready = 1'b0;
    tick();
    check("start_busy", 32'(o_busy), 32'd1);
    check("start_number", 32'(o_number), 32'd1);
    for (int c = 0; c < 400 && sb.size() > 0; c++) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pause_at > 0 && !paused && int'(o_number) == pause_at) begin
        paused = 1'b1;
        en = 1'b0;
        for (int p = 0; p < 3; p++) begin
          tick();
          check("pause_valid", 32'(o_valid), 32'd0);
          check("pause_number", 32'(o_number), 32'(pause_at));
        end
        en = 1'b1;
      end
      if (!changed && o_number == 5'd10) begin
        changed = 1'b1;
        div = d_mid;
      end
      tick();
    end
    check("run_drained", 32'(sb.size()), 32'd0);
    check("end_done", 32'(o_done), 32'd1);
    check("end_busy", 32'(o_busy), 32'd0);
    check("end_valid", 32'(o_valid), 32'd0);
    check("end_number", 32'(o_number), 32'(c_len));
    en = 1'b0;
    tick();
    check("idle_number", 32'(o_number), 32'd0);
    check("idle_done", 32'(o_done), 32'd0);
    check("idle_hit", 32'(o_hit), 32'd0);
  endtask

  initial begin
    #3;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_zero("idle_after_reset");

    // Basic run, divisors ch0=3, ch1=5
    run({5'd5, 5'd3}, 1'b0, 0, {5'd5, 5'd3});
    // Random backpressure
    run({5'd5, 5'd3}, 1'b1, 0, {5'd5, 5'd3});
    // Disabled / always-hit channels, divisor change mid-run
    run({5'd1, 5'd0}, 1'b0, 0, {5'd3, 5'd2});
    // Divisor beyond length, divisor change mid-run
    run({5'd25, 5'd7}, 1'b1, 0, {5'd1, 5'd1});
    // Pause at 8, then a replay from 1
    run({5'd5, 5'd3}, 1'b0, 8, {5'd5, 5'd3});
    run({5'd5, 5'd3}, 1'b0, 0, {5'd5, 5'd3});

    // Async reset at number 11
    div = {5'd5, 5'd3};
    for (int n = 1; n <= c_len; n++) push(n, div);
    en = 1'b1;
    ready = 1'b1;
    tick();
    for (int c = 0; c < 100 && o_number != 5'd11; c++) tick();
    check("reached_11", 32'(o_number), 32'd11);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    sb.delete();
    prev_stall = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run({5'd5, 5'd3}, 1'b0, 0, {5'd5, 5'd3});

    // Wrap mode, divisors ch0=3, ch1=4, 45 beats
    sel = 1'b1;
    prev_stall = 1'b0;
    div = {5'd4, 5'd3};
    for (int i = 0; i < 45; i++) push((i % c_len) + 1, div);
    en = 1'b1;
    ready = 1'b1;
    tick();
    check("wrap_start_number", 32'(o_number), 32'd1);
    for (int c = 0; c < 200 && sb.size() > 0; c++) tick();
    check("wrap_drained", 32'(sb.size()), 32'd0);
    en = 1'b0;
    tick();
    check("wrap_pause_valid", 32'(o_valid), 32'd0);
    check("wrap_busy", 32'(o_busy), 32'd1);
    check("wrap_number", 32'(o_number), 32'd6);
    check("wrap_done", 32'(o_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
